// File: rtl/demap_serializer.sv
// demap_serializer: Gray-coded BPSK/QPSK/16-QAM hard slicer and bit serializer; DEMAP_FRAME_EN adds the frame bit counter and frame_done
module demap_serializer #(
    parameter int DEMAPPER = 16,
    parameter int IQ_WIDTH = 8,
    parameter logic [IQ_WIDTH-2:0] THRESH = 40,
    parameter int FRAME_BITS = 16384
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       valid_in,
    input  logic signed [IQ_WIDTH-1:0] i_in,
    input  logic signed [IQ_WIDTH-1:0] q_in,
    output logic                       ready_out,
    output logic                       data_out,
    output logic                       we_out,
    output logic                       frame_done
);
    localparam int K = DEMAPPER == 2 ? 1 : DEMAPPER == 4 ? 2 : 4;
    localparam logic [1:0] LAST = 2'(K - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, next_state;
    logic [1:0] idx;
    logic [3:0] sr, bits;
    logic accept, emit;
    function automatic logic [IQ_WIDTH-2:0] mag(input logic signed [IQ_WIDTH-1:0] x);
        logic [IQ_WIDTH-1:0] n;
        n = -x;
        return !x[IQ_WIDTH-1] ? x[IQ_WIDTH-2:0] : n[IQ_WIDTH-1] ? '1 : n[IQ_WIDTH-2:0];
    endfunction
    assign bits = K == 1 ? {3'b0, ~i_in[IQ_WIDTH-1]} :
                  K == 2 ? {2'b0, ~q_in[IQ_WIDTH-1], ~i_in[IQ_WIDTH-1]} :
                  {mag(q_in) < THRESH, ~q_in[IQ_WIDTH-1], mag(i_in) < THRESH, ~i_in[IQ_WIDTH-1]};
    assign accept = valid_in && ready_out && !clear;
    assign emit = state == SHIFT && !clear;
    always_comb begin
        next_state = state;
        ready_out = state == IDLE || idx == LAST;
        if (clear) next_state = IDLE;
        else if (accept) next_state = SHIFT;
        else if (state == SHIFT && idx == LAST) next_state = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            sr <= '0;
            data_out <= 1'b0;
            we_out <= 1'b0;
        end else begin
            state <= next_state;
            we_out <= emit;
            if (emit) data_out <= sr[0];
            if (clear) begin
                idx <= '0;
                sr <= '0;
            end else if (accept) begin
                idx <= '0;
                sr <= bits;
            end else if (state == SHIFT) begin
                idx <= idx + 2'd1;
                sr <= {1'b0, sr[3:1]};
            end
        end
    end
`ifdef DEMAP_FRAME_EN
    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LASTC = CW'(FRAME_BITS - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= emit && cnt == LASTC;
            if (emit) cnt <= cnt == LASTC ? '0 : cnt + 1'b1;
        end
    end
`else
    assign frame_done = 1'b0;
`endif
endmodule

// File: tb/tb_demap_serializer.sv
// tb_demap_serializer: random and directed stimulus on BPSK/QPSK/16-QAM instances against a bit-queue reference model
module tb_demap_serializer;
    localparam int FB = 16384;
`ifdef DEMAP_FRAME_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
    logic [2:0] vld = '0, rdy, dat, we, fd;
    logic signed [7:0] iv[3], qv[3];
    int pcnt[3], pbits[3], fcnt[3];
    logic ed[3], ewe[3], efd[3];
    int checks = 0, errors = 0;
    int cap_n = -1, capn = 0, fdn = 0;
    logic [15:0] cap = '0;
    always #5 clk = ~clk;
    demap_serializer #(.DEMAPPER(2)) u_bpsk (.clk(clk), .reset(reset), .clear(clear), .valid_in(vld[0]),
        .i_in(iv[0]), .q_in(qv[0]), .ready_out(rdy[0]), .data_out(dat[0]), .we_out(we[0]), .frame_done(fd[0]));
    demap_serializer #(.DEMAPPER(4)) u_qpsk (.clk(clk), .reset(reset), .clear(clear), .valid_in(vld[1]),
        .i_in(iv[1]), .q_in(qv[1]), .ready_out(rdy[1]), .data_out(dat[1]), .we_out(we[1]), .frame_done(fd[1]));
    demap_serializer #(.DEMAPPER(16)) u_qam (.clk(clk), .reset(reset), .clear(clear), .valid_in(vld[2]),
        .i_in(iv[2]), .q_in(qv[2]), .ready_out(rdy[2]), .data_out(dat[2]), .we_out(we[2]), .frame_done(fd[2]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int mag(input int x);
        return x == -128 ? 127 : x < 0 ? -x : x;
    endfunction
    function automatic int kof(input int n);
        return n == 0 ? 1 : n == 1 ? 2 : 4;
    endfunction
    function automatic int spec_bits(input int n, input int i, input int q);
        int b0, b1, b2, b3;
        b0 = i >= 0 ? 1 : 0;
        b1 = mag(i) < 40 ? 1 : 0;
        b2 = q >= 0 ? 1 : 0;
        b3 = mag(q) < 40 ? 1 : 0;
        return n == 0 ? b0 : n == 1 ? b0 | (b2 << 1) : b0 | (b1 << 1) | (b2 << 2) | (b3 << 3);
    endfunction
    task automatic cycle();
        logic [2:0] acc;
        #1;
        for (int n = 0; n < 3; n++) check($sformatf("ready%0d", n), 32'(rdy[n]), 32'(pcnt[n] <= 1));
        for (int n = 0; n < 3; n++) begin
            acc[n] = vld[n] && pcnt[n] <= 1 && !clear;
            if (clear) begin
                pcnt[n] = 0; pbits[n] = 0; fcnt[n] = 0; ewe[n] = 1'b0; efd[n] = 1'b0;
            end else begin
                ewe[n] = pcnt[n] > 0;
                efd[n] = 1'b0;
                if (pcnt[n] > 0) begin
                    ed[n] = pbits[n][0];
                    pbits[n] = pbits[n] >> 1;
                    pcnt[n]--;
                    efd[n] = FEN && fcnt[n] == FB - 1;
                    fcnt[n] = (fcnt[n] + 1) % FB;
                end
                if (acc[n]) begin
                    pbits[n] = spec_bits(n, int'(iv[n]), int'(qv[n]));
                    pcnt[n] = kof(n);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("we%0d", n), 32'(we[n]), 32'(ewe[n]));
            check($sformatf("data%0d", n), 32'(dat[n]), 32'(ed[n]));
            check($sformatf("frame_done%0d", n), 32'(fd[n]), 32'(efd[n]));
        end
        if (cap_n >= 0 && we[cap_n]) begin
            cap = {cap[14:0], dat[cap_n]};
            capn++;
        end
        if (fd[0]) fdn++;
    endtask
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("rst_ready%0d", n), 32'(rdy[n]), 32'd1);
            check($sformatf("rst_we%0d", n), 32'(we[n]), 32'd0);
            check($sformatf("rst_data%0d", n), 32'(dat[n]), 32'd0);
            check($sformatf("rst_fd%0d", n), 32'(fd[n]), 32'd0);
            pcnt[n] = 0; pbits[n] = 0; fcnt[n] = 0; ed[n] = 1'b0; ewe[n] = 1'b0; efd[n] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic send(input int n, input int i, input int q);
        bit done = 1'b0;
        vld[n] = 1'b1;
        iv[n] = 8'(i);
        qv[n] = 8'(q);
        for (int t = 0; t < 8 && !done; t++) begin
            done = pcnt[n] <= 1 && !clear;
            cycle();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask
    task automatic idle(input int c);
        vld = '0;
        repeat (c) cycle();
    endtask
    task automatic start_cap(input int n);
        cap_n = n;
        cap = '0;
        capn = 0;
    endtask
    initial begin
        for (int n = 0; n < 3; n++) begin
            iv[n] = '0; qv[n] = '0;
        end
        do_reset();
        idle(2);
        start_cap(2);
        send(2, 60, -60); send(2, 20, -20); send(2, -20, 20); send(2, -60, 60);
        idle(5);
        check("qam_stream", 32'(cap), 32'h8D72);
        check("qam_count", 32'(capn), 32'd16);
        start_cap(2);
        send(2, 0, 0); send(2, 40, 40); send(2, -128, -128); send(2, -40, 39);
        idle(5);
        check("qam_bounds", 32'(cap), 32'hFA03);
        start_cap(1);
        send(1, 0, -1);
        idle(3);
        check("qpsk_0_m1", 32'(cap), 32'b10);
        start_cap(1);
        send(1, 5, 5); send(1, -5, 5); send(1, 5, -5);
        idle(3);
        check("qpsk_backpressure", 32'(cap), 32'b110110);
        check("qpsk_bp_count", 32'(capn), 32'd6);
        send(2, 60, 20);
        vld = '0;
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        start_cap(2);
        idle(2);
        check("clear_no_tail", 32'(capn), 32'd0);
        send(2, -20, -60);
        idle(5);
        check("after_clear", 32'(cap), 32'b0100);
        send(2, 60, 60);
        do_reset();
        start_cap(2);
        idle(4);
        check("reset_no_tail", 32'(capn), 32'd0);
        cap_n = -1;
        for (int c = 0; c < 3000; c++) begin
            int pool[11] = '{-128, -41, -40, -39, -1, 0, 1, 39, 40, 41, 127};
            for (int n = 0; n < 3; n++) begin
                vld[n] = $urandom_range(0, 1);
                iv[n] = $urandom_range(0, 1) ? 8'(pool[$urandom_range(0, 10)]) : 8'($urandom);
                qv[n] = $urandom_range(0, 1) ? 8'(pool[$urandom_range(0, 10)]) : 8'($urandom);
            end
            clear = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 499) == 0) begin
                clear = 1'b0;
                do_reset();
            end
            cycle();
        end
        clear = 1'b0;
        idle(5);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        fdn = 0;
        for (int s = 0; s < FB + 1; s++) send(0, $urandom_range(0, 1) ? 5 : -5, 0);
        idle(3);
        check("frame_pulses", 32'(fdn), FEN ? 32'd1 : 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
